// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button input conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  localparam int DB_CYCLES_DEFAULT = 500000;
  localparam int DB_CYCLES_SIM     = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: polarity normalisation, 2-flop synchronizer,
// stability counter and press/release FSM with registered strobes.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic release_strb,
  output logic pulse_nxt
);

  localparam int            CW       = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic          w_p;
  logic          r_s1;
  logic          r_s2;
  chan_state_e   r_state;
  chan_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          w_level_nxt;
  logic          r_pulse;
  logic          w_pulse_nxt;
  logic          r_release;
  logic          w_release_nxt;

  assign w_p = raw ^ ACTIVE_LOW;

  // Synchronizer; reset loads the normalised "released" value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_p;
      r_s2 <= r_s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RELEASED;
      r_cnt     <= CNT_ZERO;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_pulse   <= w_pulse_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next state: a level change is accepted only after DB_CYCLES equal samples.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_pulse_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_s2) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!r_s2) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = CNT_ZERO;
          w_level_nxt = 1'b1;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!r_s2) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = HELD;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      RELEASE_WAIT: begin
        if (r_s2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = CNT_ZERO;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = CNT_ZERO;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign level        = r_level;
  assign pulse        = r_pulse;
  assign release_strb = r_release;
  assign pulse_nxt    = w_pulse_nxt;

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN raw push-buttons into clean levels, press/release
// strobes and a combined any-press strobe aligned with the per-button pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN    = 3,
  parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_pulse
);

  logic [NUM_BTN-1:0] w_pulse_nxt;
  logic               r_any_pulse;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .raw         (btn_raw[g]),
      .level       (btn_level[g]),
      .pulse       (btn_pulse[g]),
      .release_strb(btn_release[g]),
      .pulse_nxt   (w_pulse_nxt[g])
    );
  end

  // Register the OR of next-cycle pulses so any_pulse lines up with btn_pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any_pulse <= 1'b0;
    end else begin
      r_any_pulse <= |w_pulse_nxt;
    end
  end

  assign any_pulse = r_any_pulse;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the button decoder.
- Takes the three raw, asynchronous push-button inputs from the board pins. Each input is synchronized, debounced, and turned into a clean level plus a single-cycle press pulse.
- The clean press pulses are the `buttons` vector the decoder routes to the selected player group. Each button is processed independently, so simultaneous presses are supported.

Parameters:
- NUM_BTN, 3, number of button channels.
- DB_CYCLES, 500000, consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz). Must be ≥ 2.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (board default); 0 = pressed reads 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn_raw  in  NUM_BTN  raw pin levels, asynchronous to clk
- btn_level  out  NUM_BTN  debounced level, 1 = pressed, independent of ACTIVE_LOW
- btn_pulse  out  NUM_BTN  one-cycle strobe on each accepted press
- btn_release  out  NUM_BTN  one-cycle strobe on each accepted release
- any_pulse  out  1  OR of btn_pulse, registered in the same cycle as btn_pulse

Behaviour:
- Reset (async assert, sync-safe deassert handled at board level):
  - btn_level, btn_pulse, btn_release and any_pulse go to 0.
  - Sync flops load the "released" value.
  - All counters go to 0 and all channel FSMs to RELEASED.
- Reset mid-operation, including during PRESS_WAIT or HELD: channel returns to RELEASED, and no pulse or release strobe is emitted on exit.
- Input normalization: p = btn_raw XOR ACTIVE_LOW, so 1 = pressed. This is followed by a 2-flop synchronizer (s1, s2) per channel.
- Per-channel FSM states: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
  - RELEASED: s2=1 → PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT, s2=0 → RELEASED with cnt=0 (bounce rejected).
  - PRESS_WAIT, s2=1 and cnt=DB_CYCLES-1 → HELD. The same edge registers btn_level=1 and btn_pulse=1.
  - PRESS_WAIT, otherwise: cnt+1.
  - HELD: s2=0 → RELEASE_WAIT with cnt=1; otherwise stay.
  - RELEASE_WAIT, s2=1 → HELD with cnt=0.
  - RELEASE_WAIT, s2=0 and cnt=DB_CYCLES-1 → RELEASED. The same edge registers btn_level=0 and btn_release=1.
  - RELEASE_WAIT, otherwise: cnt+1.
- Counter:
  - Width is clog2(DB_CYCLES)+1, unsigned.
  - Never exceeds DB_CYCLES-1.
  - No wrap is possible.
- Latency, for a clean input:
  - Let the first edge sampling pressed into s1 be edge N.
  - btn_pulse is high for exactly the one cycle after edge N+1+DB_CYCLES.
  - Release behaves symmetrically on btn_release.
- btn_pulse and btn_release:
  - Strictly one cycle wide.
  - Never both high on one channel in the same cycle.
  - A held button produces exactly one pulse; there is no auto-repeat.
- Bounce rule: any glitch shorter than DB_CYCLES synchronized cycles produces no output change.
- Channels are fully independent. Same-cycle presses on several channels give same-cycle pulses, with any_pulse=1 for one cycle.
- All outputs are registered; there is no combinational path from btn_raw to any output.

Decomposition:
- Shared package:
  - channel state enum (RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT) as 2-bit encoding;
  - default DB_CYCLES constant;
  - sim-friendly DB_CYCLES_SIM=4 constant used by benches.
- Sub-module debounce_channel: one channel, i.e. synchronizer, counter and FSM.
  - Ports: clk, rst, raw, level, pulse, release.
  - Parameterized by DB_CYCLES and ACTIVE_LOW.
- Top instantiates it NUM_BTN times via generate and ORs the pulses into any_pulse through one register.

Test Plan (DB_CYCLES=4, ACTIVE_LOW=1, 20 ns clock):
- Reset check:
  - Stimulus: rst=1 with btn_raw=3'b111, then deassert and hold raw for 20 cycles.
  - Required: all outputs stay 0 and no pulse occurs.
- Clean press on button 0:
  - Stimulus: btn_raw=3'b110, captured at edge N.
  - Required: btn_pulse=3'b001 for exactly the cycle after edge N+5, and btn_level[0]=1 from then on.
- Bounce rejection:
  - Stimulus: btn_raw[1] toggles press/release every 2 cycles for 16 cycles, then returns to released.
  - Required: btn_pulse, btn_release and btn_level stay 0.
- Hold then release:
  - Stimulus: press btn 2 for 30 cycles, then release.
  - Required: exactly one btn_pulse[2] and exactly one btn_release[2], the release strobe 5 cycles after release capture. btn_level[2] falls in the same cycle as the strobe.
- Simultaneous press:
  - Stimulus: btn_raw 3'b111→3'b000 on one edge.
  - Required: btn_pulse=3'b111 and any_pulse=1 for one cycle.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while button 0 is in PRESS_WAIT (cnt=2) and button 1 is HELD.
  - Required: all outputs drop to 0 immediately with no strobe. After deassert, still-pressed buttons re-debounce and pulse again after N+5.
